load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly upstream of the word-only data memory in the pipelined RV32I core. Translates byte addresses to word indices, performs sign/zero extension of LB/LH/LBU/LHU/LW results, and implements SB/SH as a read-modify-write, because the data memory has no byte enables. Stalls the pipeline for one cycle per sub-word store and flags misaligned accesses.

---
 rtl/rv_lsu_pkg.sv | 33 +++
 rtl/lsu_load_align.sv | 31 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
`timescale 1ns/1ps
package rv_lsu_pkg;

  localparam int LSU_DEPTH_WORDS = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Stores only know B/H/W; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane select and sign/zero extension of a raw memory word for loads.
`timescale 1ns/1ps
module lsu_load_align
  import rv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [3:0][7:0] rb;
  logic [7:0]      b;
  logic [15:0]     h;

  assign rb = rdata;

  // Pick the addressed byte/half and extend according to funct3.
  always_comb begin
    b = rb[lane];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-only data memory.
// Sub-word stores are done as read-modify-write with a one-cycle stall.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/W
// accesses are rejected and flagged on misalign; otherwise the low address
// bits are forced to natural alignment and the access goes ahead.
`timescale 1ns/1ps
module load_store_unit
  import rv_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = LSU_DEPTH_WORDS,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  lsu_req_t         req;
  lsu_state_e       state, state_nx;
  logic [IDX_W-1:0] idx, rmw_idx, addr_idx;
  logic [1:0]       lane;
  logic             legal, rej, acc, acc_ld, acc_sw, acc_sub, mis_hit;
  logic [31:0]      ext_data, merge_q;
  logic [3:0][7:0]  rd_b, st_b, mrg_b;
  logic [3:0]       be;

  assign req = '{valid: req_valid, we: req_we, funct3: req_funct3,
                 addr: req_addr, wdata: req_wdata};

  // Address bits above the word index wrap away by design.
  logic unused_addr;
  assign unused_addr = ^req.addr[31:IDX_W+2];

  // Decode: word index, effective byte lane, and which access is taken.
  always_comb begin
    idx   = req.addr[IDX_W+1:2];
    legal = f3_legal(req.we, req.funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    rej  = ((req.funct3[1:0] == 2'b01) && req.addr[0]) ||
           ((req.funct3[1:0] == 2'b10) && (req.addr[1:0] != 2'b00));
    lane = req.addr[1:0];
`else
    rej = 1'b0;
    case (req.funct3[1:0])
      2'b01:   lane = {req.addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = req.addr[1:0];
    endcase
`endif
    acc     = (state == IDLE) && req.valid && legal && !rej;
    acc_ld  = acc && !req.we;
    acc_sw  = acc && req.we && (req.funct3 == F3_W);
    acc_sub = acc && req.we && (req.funct3 != F3_W);
    mis_hit = (state == IDLE) && req.valid && legal && rej;
  end

  // Store merge: replicate store data across lanes, keep read bytes elsewhere.
  assign rd_b = mem_rd;
  assign st_b = (req.funct3[1:0] == 2'b00) ? {4{req.wdata[7:0]}}
                                           : {2{req.wdata[15:0]}};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign be[i]    = (req.funct3[1:0] == 2'b00) ? (lane == 2'(i))
                                                 : (lane[1] == 1'(i / 2));
    assign mrg_b[i] = be[i] ? st_b[i] : rd_b[i];
  end

  lsu_load_align u_align (
    .rdata  (mem_rd),
    .lane   (lane),
    .funct3 (req.funct3),
    .data   (ext_data)
  );

  // Next state and memory-side outputs; reset forces everything quiet.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    addr_idx = '0;
    case (state)
      IDLE: begin
        if (req.valid) addr_idx = idx;
        if (acc_sw) begin
          mem_we = 1'b1;
          mem_wd = req.wdata;
        end
        if (acc_sub) begin
          stall    = 1'b1;
          state_nx = RMW_WRITE;
        end
      end
      RMW_WRITE: begin
        mem_we   = 1'b1;
        mem_wd   = merge_q;
        addr_idx = rmw_idx;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      stall    = 1'b0;
      mem_we   = 1'b0;
      mem_wd   = '0;
      addr_idx = '0;
    end
  end

  assign mem_addr = {{(32 - IDX_W){1'b0}}, addr_idx};

  // State, registered load result, pulses and RMW capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      merge_q    <= '0;
      rmw_idx    <= '0;
    end else begin
      state      <= state_nx;
      load_valid <= acc_ld;
      misalign   <= mis_hit;
      if (acc_ld) load_data <= ext_data;
      if (acc_sub) begin
        merge_q <= mrg_b;
        rmw_idx <= idx;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-only memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int DEPTH = 64;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, load_valid, misalign, mem_we;
  logic [31:0] load_data, mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [DEPTH];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic [31:0] refmem [DEPTH];

  logic [31:0] exp_ld [$];
  wr_t         exp_wr [$];
  int          exp_mis [$];
  int          exp_stall [$];
  logic [31:0] last_ld = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misalign(misalign), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Data memory: combinational read, write on the falling edge.
  assign mem_rd = mem[mem_addr[5:0]];
  always @(negedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_addr[5:0]] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed semantics on an array of words.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit abort);
    int sz, off, idx;
    bit legal;
    longint unsigned m, w, v;
    idx = int'((a / 4) % DEPTH);
    off = int'(a % 4);
    case (f3 % 4)
      0: sz = 1;
      1: sz = 2;
      2: sz = 4;
      default: sz = 0;
    endcase
    legal = we ? (f3 < 3) : (f3 != 3 && f3 < 6);
    if (!legal) return;
    if (off % sz != 0) begin
      if (TRAP) begin
        exp_mis.push_back(1);
        return;
      end
      off = off - off % sz;
    end
    m = ((64'd1 << (8 * sz)) - 1) << (8 * off);
    w = 64'(refmem[idx]);
    if (!we) begin
      v = (w & m) >> (8 * off);
      if (f3 < 4 && sz < 4 && v[8 * sz - 1]) v = v | ~((64'd1 << (8 * sz)) - 1);
      exp_ld.push_back(v[31:0]);
    end else begin
      if (sz < 4) exp_stall.push_back(1);
      if (abort) return;
      v = (w & ~m) | ((64'(wd) << (8 * off)) & m);
      refmem[idx] = v[31:0];
      exp_wr.push_back('{32'(idx), v[31:0]});
    end
  endtask

  // Called just after a rising edge; holds the request while the DUT stalls.
  task automatic issue(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int guard;
    logic st;
    guard = 0;
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (v) model(we, f3, a, wd, 1'b0);
    do begin
      @(negedge clk);
      st = stall;
      @(posedge clk);
      #1;
      guard++;
    end while (st && guard < 4);
    if (guard >= 4) begin
      checks++;
      errors++;
      $display("FAIL stall_bound: got stall after %0d cycles expected release", guard);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      last_ld = '0;
    end else begin
      if (load_valid) begin
        if (exp_ld.size() == 0) chk("unexpected_load_valid", load_data, 32'hx);
        else begin
          chk("load_data", load_data, exp_ld.pop_front());
          last_ld = load_data;
        end
      end
      if (misalign) begin
        if (exp_mis.size() == 0) chk("unexpected_misalign", 32'(misalign), 32'd0);
        else begin
          void'(exp_mis.pop_front());
          chk("misalign_load_data_kept", load_data, last_ld);
        end
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_mem_we", mem_addr, 32'hx);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wd, e.data);
        end
      end
      if (stall) begin
        if (exp_stall.size() == 0) chk("unexpected_stall", 32'(stall), 32'd0);
        else void'(exp_stall.pop_front());
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_load_valid"}, 32'(load_valid), 32'd0);
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    logic [31:0] val;
    // Preload memory and reference with the same contents while in reset.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      val = (i == 3) ? 32'h8070_60F0 : (i == 1) ? 32'h1357_9BDF : $urandom;
      pl_en = 1'b1; pl_idx = 6'(i); pl_val = val;
      refmem[i] = val;
    end
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    @(negedge clk);
    chk("in_reset_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;

    // Directed cases.
    issue(1, 0, 3'b000, 32'h0C, 32'h0);          // LB  -> FFFF_FFF0
    issue(1, 0, 3'b100, 32'h0F, 32'h0);          // LBU -> 0000_0080
    issue(1, 0, 3'b001, 32'h0E, 32'h0);          // LH  -> FFFF_8070
    issue(1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);  // SW word 4
    issue(1, 0, 3'b010, 32'h10, 32'h0);          // LW
    issue(1, 1, 3'b000, 32'h11, 32'h0000_0055);  // SB -> DEAD_55EF
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(1, 0, 3'b010, 32'h06, 32'h0);          // misaligned LW
    issue(1, 1, 3'b001, 32'h12, 32'hAAAA_1234);  // SH upper half
    issue(1, 1, 3'b000, 32'h20, 32'h11);         // back-to-back SB, same word
    issue(1, 1, 3'b000, 32'h21, 32'h22);
    issue(1, 0, 3'b010, 32'h20, 32'h0);
    issue(1, 1, 3'b010, 32'h104, 32'hCAFE_F00D); // wraps to word 1
    issue(1, 0, 3'b010, 32'h100, 32'h0);         // wraps to word 0
    issue(1, 0, 3'b011, 32'h08, 32'h0);          // illegal load
    issue(1, 1, 3'b100, 32'h08, 32'h0);          // illegal store
    issue(1, 1, 3'b001, 32'h13, 32'h7777);       // misaligned SH
    issue(0, 1, 3'b010, 32'h08, 32'h0);

    // Reset in the RMW write cycle of an SH: write must not happen.
    req_valid = 1; req_we = 1; req_funct3 = 3'b001; req_addr = 32'h1E; req_wdata = 32'h1234;
    model(1'b1, 3'b001, 32'h1E, 32'h1234, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_rmw");
    @(posedge clk);
    #1;
    issue(1, 0, 3'b010, 32'h1C, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      issue(($urandom_range(0, 7) != 0), 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end
    for (int n = 0; n < 3; n++) issue(0, 0, 3'b000, 32'h0, 32'h0);

    chk("leftover_loads", 32'(exp_ld.size()), 32'd0);
    chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
    chk("leftover_misalign", 32'(exp_mis.size()), 32'd0);
    chk("leftover_stalls", 32'(exp_stall.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
